div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle controller and iterative core for MIPS DIV/DIVU in the Execute stage.
- Accepts a start pulse with rs/rt operands and sequences a radix-2 restoring division, one quotient bit per cycle.
- Drives a stall request into the hazard unit while busy.
- Presents quotient (LO) and remainder (HI) with a one-cycle valid pulse for the HI/LO write path.

Parameters:
- DATA_W, 32, operand/result width; the iteration count equals DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  division request from Execute; sampled only in IDLE.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
- opa_i  in  DATA_W  dividend (rs value after forwarding).
- opb_i  in  DATA_W  divisor (rt value after forwarding).
- annul_i  in  1  flush of the owning instruction; aborts the operation.
- stall_o  out  1  stall request to the hazard unit.
- valid_o  out  1  one-cycle pulse; hi_o/lo_o are new this cycle.
- hi_o  out  DATA_W  remainder, registered.
- lo_o  out  DATA_W  quotient, registered.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, counter=0, all internal datapath registers 0.
  - valid_o=0, hi_o=0, lo_o=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1, annul_i=0, opb_i!=0: latch |opa| and |opb| (the raw values when signed_i=0).
  - On that accept, also latch the quotient sign (opa[MSB]^opb[MSB])&signed_i and the remainder sign opa[MSB]&signed_i; clear the partial remainder and counter; go to RUN.
  - start_i=1, annul_i=0, opb_i==0 (divide by zero): go directly to DONE with lo=all ones and hi=opa_i unmodified, regardless of signed_i.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle, shift {rem,quo} left 1 and trial-subtract the divisor from rem (DATA_W+1 bit subtract).
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - counter increments each cycle; after DATA_W iterations (counter==DATA_W-1 at the clock edge) go to DONE.
- DONE:
  - Signed-correct the results (negate the quotient if its sign flag is set; negate the remainder if its sign flag is set).
  - Register them into lo_o/hi_o, assert valid_o for exactly this one cycle, then return to IDLE.
  - The fix-up is done on the RUN→DONE edge so the outputs are stable throughout DONE.
- stall_o is combinational: (IDLE & start_i & ~annul_i) | RUN. It is 0 in DONE, so the instruction advances in the cycle valid_o=1.
- Latency: start accepted in cycle t; RUN occupies t+1..t+DATA_W; valid_o=1 in cycle t+DATA_W+1 (cycle 33 for DATA_W=32).
  - Divide by zero: valid_o=1 in cycle t+1.
- annul_i=1 in any state:
  - Next state is IDLE, no valid_o pulse, and hi_o/lo_o keep their previous values.
  - annul_i has priority over start_i and over completion.
- start_i while RUN/DONE is ignored; no queueing.
- hi_o/lo_o hold their value until the next valid_o.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0. No trap.
- Reset asserted mid-operation: immediate return to the reset state; no valid_o is ever generated for the aborted op.

Test Plan:
- DIVU 100/7, start at cycle 0 → stall_o=1 for cycles 0..32; valid_o=1 at cycle 33 only; lo=14, hi=2.
- DIV opa=0xFFFFFFF9 (-7), opb=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7/-2 → lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0; DIVU of the same operands → lo=0, hi=0x80000000.
- Divide by zero: DIVU 0x1234/0 → valid_o at cycle 1; lo=0xFFFFFFFF, hi=0x1234; stall_o high only in cycle 0.
- annul_i pulsed at cycle 10 of a DIVU 50/5 → no valid_o and hi/lo unchanged; a new start at cycle 12 completes correctly at cycle 45.
- rst asserted asynchronously mid-RUN → all outputs 0 immediately; start_i pulsed while RUN is ignored, and the original op's result is unaffected.

Source files
------------

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// stalls the pipeline while busy and pulses valid_o with the signed-corrected HI/LO.
module div_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic              annul_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic              q_neg_q, r_neg_q;

    logic              opa_neg, opb_neg;
    logic [DATA_W-1:0] opa_abs, opb_abs;
    logic [DATA_W:0]   rem_sh, diff;
    logic [DATA_W-1:0] rem_nxt, quo_nxt;

    always_comb begin
        opa_neg = signed_i & opa_i[DATA_W-1];
        opb_neg = signed_i & opb_i[DATA_W-1];
        opa_abs = opa_neg ? -opa_i : opa_i;
        opb_abs = opb_neg ? -opb_i : opb_i;
    end

    // rem < divisor always holds, so bit DATA_W of the difference is a reliable borrow.
    always_comb begin
        rem_sh = {rem_q, quo_q[DATA_W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (!diff[DATA_W]) begin
            rem_nxt = diff[DATA_W-1:0];
            quo_nxt = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[DATA_W-1:0];
            quo_nxt = {quo_q[DATA_W-2:0], 1'b0};
        end
    end

    assign stall_o = ((state_q == StIdle) & start_i & ~annul_i) | (state_q == StRun);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            valid_o <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            valid_o <= 1'b0;
            if (annul_i) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            if (opb_i == '0) begin
                                lo_o    <= '1;
                                hi_o    <= opa_i;
                                valid_o <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                quo_q   <= opa_abs;
                                dvs_q   <= opb_abs;
                                rem_q   <= '0;
                                cnt_q   <= '0;
                                q_neg_q <= opa_neg ^ opb_neg;
                                r_neg_q <= opa_neg;
                                state_q <= StRun;
                            end
                        end
                    end
                    StRun: begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        // Sign fix-up on the final edge keeps hi_o/lo_o stable through DONE.
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            lo_o    <= q_neg_q ? -quo_nxt : quo_nxt;
                            hi_o    <= r_neg_q ? -rem_nxt : rem_nxt;
                            valid_o <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                    StDone: state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: stimulus pushes model results with their due cycle,
// a negedge monitor pops on valid_o and also tracks stall_o and output hold.
module tb_div_sequencer;

    localparam int unsigned DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [31:0] opa_i = '0;
    logic [31:0] opb_i = '0;
    logic        stall_o, valid_o;
    logic [31:0] hi_o, lo_o;

    always #5 clk = ~clk;

    div_sequencer #(.DATA_W(DATA_W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .annul_i  (annul_i),
        .stall_o  (stall_o),
        .valid_o  (valid_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        scb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_from = 0;
    int          busy_to = -1;
    logic        stall_exp;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // MIPS semantics from plain arithmetic: {hi, lo} = {remainder, quotient}.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        int signed sa, sb, q, r;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            stall_exp = (cyc >= busy_from) && (cyc <= busy_to);
            chk("stall", 32'(stall_o), 32'(stall_exp));
            if (valid_o) begin
                if (scb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid at cycle %0d: got hi=%h lo=%h, expected no pulse",
                             cyc, hi_o, lo_o);
                end else begin
                    mon_e = scb.pop_front();
                    chk("lo", lo_o, mon_e.lo);
                    chk("hi", hi_o, mon_e.hi);
                    chk("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
                    last_hi = mon_e.hi;
                    last_lo = mon_e.lo;
                end
            end else begin
                chk("hold_hi", hi_o, last_hi);
                chk("hold_lo", lo_o, last_lo);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit expect_result);
        logic [63:0] r;
        int          lat;
        @(posedge clk);
        #1;
        start_i   = 1'b1;
        signed_i  = s;
        opa_i     = a;
        opb_i     = b;
        lat       = (b == 32'h0) ? 1 : DATA_W + 1;
        busy_from = cyc;
        busy_to   = cyc + lat - 1;
        if (expect_result) begin
            r = model(a, b, s);
            scb.push_back('{hi: r[63:32], lo: r[31:0], cyc: cyc + lat});
        end
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        signed_i = 1'($urandom_range(0, 1));
        opa_i    = $urandom;
        opb_i    = $urandom;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'($urandom_range(0, 20));
            1: return 32'h0;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb;
        #1 rst = 1'b1;
        #2;
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(32'd100, 32'd7, 1'b0, 1);
        repeat (35) @(posedge clk);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1);
        repeat (35) @(posedge clk);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1);
        repeat (35) @(posedge clk);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);
        repeat (35) @(posedge clk);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1);
        repeat (35) @(posedge clk);
        issue(32'h1234, 32'h0, 1'b0, 1);
        repeat (4) @(posedge clk);

        // Annul at cycle start+10, restart at start+12.
        issue(32'd50, 32'd5, 1'b0, 0);
        repeat (9) @(posedge clk);
        #1;
        annul_i = 1'b1;
        busy_to = cyc;
        @(posedge clk);
        #1 annul_i = 1'b0;
        chk("annul_hold_lo", lo_o, last_lo);
        issue(32'd50, 32'd5, 1'b0, 1);
        repeat (35) @(posedge clk);

        // A start pulse (here a divide-by-zero) while RUN must be ignored.
        issue(32'd1000, 32'd3, 1'b0, 1);
        repeat (4) @(posedge clk);
        #1;
        start_i = 1'b1;
        opa_i   = 32'h55;
        opb_i   = 32'h0;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (30) @(posedge clk);

        // Asynchronous reset mid-RUN drops the pending op.
        issue(32'hDEAD_BEEF, 32'h1234, 1'b1, 1);
        repeat (15) @(posedge clk);
        #3;
        busy_to = -1;
        rst     = 1'b1;
        #1;
        chk("arst_hi", hi_o, 32'h0);
        chk("arst_lo", lo_o, 32'h0);
        chk("arst_valid", 32'(valid_o), 32'h0);
        chk("arst_stall", 32'(stall_o), 32'h0);
        scb.delete();
        last_hi = '0;
        last_lo = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            ra = pick();
            rb = pick();
            issue(ra, rb, 1'($urandom_range(0, 1)), 1);
            repeat (35) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(scb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
